input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner.sv | 130 +++++++++++++
 tb/tb_input_conditioner.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes, debounces and edge-detects two push-buttons and four slide
// switches, and flags long key presses.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   rst          synchronous active-high reset
//   KEY[1:0]     raw asynchronous push-buttons, active-low (0 = pressed)
//   SW[3:0]      raw asynchronous slide switches
//   key_pressed  debounced key level, active-high
//   key_press    one-cycle pulse per key on a debounced press
//   key_release  one-cycle pulse per key on a debounced release
//   key_long     one-cycle pulse per key when a press lasts LONG_PRESS_CYCLES
//   sw_out       debounced switch value
//   sw_changed   one-cycle pulse when any sw_out bit changes
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES   = 50000,
  parameter int unsigned LONG_PRESS_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] KEY,
  input  logic [3:0] SW,
  output logic [1:0] key_pressed,
  output logic [1:0] key_press,
  output logic [1:0] key_release,
  output logic [1:0] key_long,
  output logic [3:0] sw_out,
  output logic       sw_changed
);

  localparam int unsigned NumBits = 6;
  localparam int unsigned NumKeys = 2;
  localparam int unsigned CntW    = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HoldW   = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [CntW-1:0]  CntLast  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_PRESS_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldSat  = HoldW'(LONG_PRESS_CYCLES);

  // Bit order {SW, KEY}; keys idle high (released), switches idle low.
  localparam logic [NumBits-1:0] IdleLevel = 6'b00_0011;

  logic [NumBits-1:0] raw;
  logic [NumBits-1:0] sync1_q, sync1_d;
  logic [NumBits-1:0] sync2_q, sync2_d;
  logic [NumBits-1:0] stable_q, stable_d;
  logic [CntW-1:0]    cnt_q [NumBits];
  logic [CntW-1:0]    cnt_d [NumBits];

  logic [NumKeys-1:0] key_level;
  logic [NumKeys-1:0] pressed_q, pressed_d;
  logic [HoldW-1:0]   hold_q [NumKeys];
  logic [HoldW-1:0]   hold_d [NumKeys];
  logic [3:0]         sw_prev_q, sw_prev_d;

  assign raw       = {SW, KEY};
  assign key_level = ~stable_q[NumKeys-1:0];

  // Synchronizers and per-bit debounce.
  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    for (int i = 0; i < NumBits; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  // Edge history and saturating hold counters. Saturating one past the
  // pulse value keeps key_long from repeating while the key stays down.
  always_comb begin
    pressed_d = key_level;
    sw_prev_d = stable_q[NumBits-1:NumKeys];
    for (int k = 0; k < NumKeys; k++) begin
      hold_d[k] = '0;
      if (key_level[k]) begin
        hold_d[k] = (hold_q[k] == HoldSat) ? hold_q[k] : hold_q[k] + HoldW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= IdleLevel;
      sync2_q   <= IdleLevel;
      stable_q  <= IdleLevel;
      pressed_q <= '0;
      sw_prev_q <= '0;
      for (int i = 0; i < NumBits; i++) cnt_q[i] <= '0;
      for (int k = 0; k < NumKeys; k++) hold_q[k] <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      pressed_q <= pressed_d;
      sw_prev_q <= sw_prev_d;
      for (int i = 0; i < NumBits; i++) cnt_q[i] <= cnt_d[i];
      for (int k = 0; k < NumKeys; k++) hold_q[k] <= hold_d[k];
    end
  end

  // Outputs are forced quiet while rst is high so nothing stale leaks out
  // before the reset edge has taken effect.
  always_comb begin
    key_pressed = '0;
    key_press   = '0;
    key_release = '0;
    key_long    = '0;
    sw_out      = '0;
    sw_changed  = 1'b0;
    if (!rst) begin
      key_pressed = key_level;
      key_press   = key_level & ~pressed_q;
      key_release = ~key_level & pressed_q;
      for (int k = 0; k < NumKeys; k++) begin
        key_long[k] = key_level[k] && (hold_q[k] == HoldLast);
      end
      sw_out     = stable_q[NumBits-1:NumKeys];
      sw_changed = |(stable_q[NumBits-1:NumKeys] ^ sw_prev_q);
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

  localparam int unsigned Deb = 4;
  localparam int unsigned Lp  = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] KEY;
  logic [3:0] SW;
  logic [1:0] key_pressed, key_press, key_release, key_long;
  logic [3:0] sw_out;
  logic       sw_changed;

  input_conditioner #(
    .DEBOUNCE_CYCLES  (Deb),
    .LONG_PRESS_CYCLES(Lp)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .KEY        (KEY),
    .SW         (SW),
    .key_pressed(key_pressed),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .sw_out     (sw_out),
    .sw_changed (sw_changed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [1:0] kpd;
    logic [1:0] kp;
    logic [1:0] kr;
    logic [1:0] kl;
    logic [3:0] sw;
    logic       swc;
  } exp_t;

  exp_t exp_q[$];
  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input int c, input logic [1:0] kpd, input logic [1:0] kp,
                      input logic [1:0] kr, input logic [1:0] kl,
                      input logic [3:0] sw, input logic swc);
    exp_t e;
    e.cyc = c; e.kpd = kpd; e.kp = kp; e.kr = kr; e.kl = kl; e.sw = sw; e.swc = swc;
    exp_q.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: an output event is any pulse; each one consumes one expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        checks_total++;
        $display("FAIL missed_event: no event seen, expected at cycle %0d (now %0d)",
                 exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end
      if (|{key_press, key_release, key_long, sw_changed}) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {25'd0, key_press, key_release, key_long, sw_changed}, 0);
        end else begin
          e = exp_q.pop_front();
          check("event_cycle", cyc, e.cyc);
          check("key_pressed", {30'd0, key_pressed}, {30'd0, e.kpd});
          check("key_press", {30'd0, key_press}, {30'd0, e.kp});
          check("key_release", {30'd0, key_release}, {30'd0, e.kr});
          check("key_long", {30'd0, key_long}, {30'd0, e.kl});
          check("sw_out", {28'd0, sw_out}, {28'd0, e.sw});
          check("sw_changed", {31'd0, sw_changed}, {31'd0, e.swc});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got cycle %0d required finish", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    rst = 1'b1;
    KEY = 2'b11;
    SW  = 4'b0000;
    wait_cycles(3);
    check("rst_key_pressed", {30'd0, key_pressed}, 0);
    check("rst_key_pulses", {26'd0, key_press, key_release, key_long}, 0);
    check("rst_sw_out", {28'd0, sw_out}, 0);
    check("rst_sw_changed", {31'd0, sw_changed}, 0);
    rst = 1'b0;
    wait_cycles(1);
    check("post_rst_key_pressed", {30'd0, key_pressed}, 0);
    check("post_rst_sw_out", {28'd0, sw_out}, 0);
    wait_cycles(4);

    // KEY[1] held 30 cycles: press, one long pulse, release.
    t = cyc;
    KEY = 2'b01;
    push(t + 6, 2'b10, 2'b10, 2'b00, 2'b00, 4'b0000, 1'b0);
    push(t + 25, 2'b10, 2'b00, 2'b00, 2'b10, 4'b0000, 1'b0);
    wait_cycles(30);
    t = cyc;
    KEY = 2'b11;
    push(t + 6, 2'b00, 2'b00, 2'b10, 2'b00, 4'b0000, 1'b0);
    wait_cycles(10);

    // KEY[0] glitch shorter than the debounce window.
    KEY = 2'b10;
    wait_cycles(3);
    KEY = 2'b11;
    wait_cycles(10);
    check("glitch_key_pressed", {30'd0, key_pressed}, 0);

    // Switch change, then bounce that never settles long enough.
    t = cyc;
    SW = 4'b0101;
    push(t + 6, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0101, 1'b1);
    wait_cycles(10);
    for (int i = 0; i < 5; i++) begin
      SW = 4'b0100;
      wait_cycles(2);
      SW = 4'b0101;
      wait_cycles(2);
    end
    wait_cycles(10);
    check("bounce_sw_out", {28'd0, sw_out}, 32'h5);

    // Both keys and switches at the same edge.
    t = cyc;
    KEY = 2'b00;
    SW  = 4'b1111;
    push(t + 6, 2'b11, 2'b11, 2'b00, 2'b00, 4'b1111, 1'b1);
    push(t + 25, 2'b11, 2'b00, 2'b00, 2'b11, 4'b1111, 1'b0);
    wait_cycles(30);
    t = cyc;
    KEY = 2'b11;
    push(t + 6, 2'b00, 2'b00, 2'b11, 2'b00, 4'b1111, 1'b0);
    wait_cycles(10);

    // Reset mid-hold (hold count 10): no long pulse, fresh press afterwards.
    t = cyc;
    KEY = 2'b01;
    push(t + 6, 2'b10, 2'b10, 2'b00, 2'b00, 4'b1111, 1'b0);
    wait_cycles(16);
    rst = 1'b1;
    wait_cycles(1);
    check("midhold_rst_key_pressed", {30'd0, key_pressed}, 0);
    check("midhold_rst_sw_out", {28'd0, sw_out}, 0);
    check("midhold_rst_key_long", {30'd0, key_long}, 0);
    rst = 1'b0;
    t = cyc;
    push(t + 6, 2'b10, 2'b10, 2'b00, 2'b00, 4'b1111, 1'b1);
    push(t + 25, 2'b10, 2'b00, 2'b00, 2'b10, 4'b1111, 1'b0);
    wait_cycles(30);
    t = cyc;
    KEY = 2'b11;
    push(t + 6, 2'b00, 2'b00, 2'b10, 2'b00, 4'b1111, 1'b0);
    wait_cycles(10);

    check("events_outstanding", exp_q.size(), 0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
